wb_commit_queue: RTL
====================

Name: wb_commit_queue

Overview:
- Writeback buffer sitting directly upstream of the two-write-port register file.
- Accepts up to two results per cycle from the execute lanes through a valid/ready handshake and queues them in program order.
- Retires up to two entries per cycle onto the register file write ports: wa1/wd1/w1_en and wa2/wd2/w2_en.
- Guarantees the register file never sees both enables asserted to the same address.

Parameters:
- BITS, 5, register address width (32 registers).
- WIDTH, 32, data width.
- DEPTH, 8, queue entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in0_valid  input  1  lane 0 result valid; lane 0 is older than lane 1 in the same cycle.
- in0_addr  input  BITS  lane 0 destination register.
- in0_data  input  WIDTH  lane 0 result.
- in1_valid  input  1  lane 1 result valid.
- in1_addr  input  BITS  lane 1 destination register.
- in1_data  input  WIDTH  lane 1 result.
- in_ready  output  1  both lanes may be accepted this cycle.
- wb_hold  input  1  suppress retirement this cycle.
- flush  input  1  synchronous discard of all queued entries.
- wa1, wa2  output  BITS  write addresses to the register file.
- wd1, wd2  output  WIDTH  write data to the register file.
- w1_en, w2_en  output  1  write enables.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full, empty  output  1  status flags.

Behaviour:
- Reset (rst_n=0 at an edge):
  - Pointers and count go to 0; empty=1, full=0.
  - w1_en=w2_en=0; wa*/wd* go to 0.
  - in_ready reflects count=0, so it is 1 once reset is released.
- Acceptance:
  - in_ready = (DEPTH - count) >= 2, computed from the registered count only; no combinational path from wb_hold or flush.
  - A lane is accepted at an edge when its valid=1 and in_ready=1.
  - Accepted lanes are compacted: in0 then in1. in1 alone occupies one slot.
  - Valid while in_ready=0 is ignored. The source must hold the request; the block drops nothing.
- Retirement is decided from the queue state before the edge:
  - The queue is circular and FIFO-ordered; pointers wrap modulo DEPTH.
  - If wb_hold=1 or empty: nothing is popped, and the outputs register w1_en=w2_en=0 for the next cycle.
  - Else pop min(count, 2) entries. The head goes to port 1 and head+1 to port 2; outputs are registered.
  - Minimum latency: an entry accepted at edge k is presented on the write ports during the cycle following edge k+1.
- Collision: if the two popped entries share an address, only port 1 is enabled, carrying the newer (head+1) data. w2_en=0 and both entries are consumed.
- Occupancy:
  - count_next = count + accepted - popped. Simultaneous accept and pop is legal in the same cycle.
  - full = (count == DEPTH); empty = (count == 0).
- flush=1 at an edge:
  - Pointers and count go to 0 and the enables register 0.
  - Same-cycle input acceptances are discarded.
  - flush has priority over wb_hold and over acceptance.
- Reset asserted mid-operation behaves identically to flush and also zeroes the output registers.
- Data/address outputs hold their last value when the enables are 0.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined:
  - Entries addressed to register 0 are consumed normally but never enable a write port.
  - A collision involving register 0 yields no write.
  - in_ready and count are unaffected.
- Undefined: register 0 is written like any other register.

Decomposition:
- Package wb_pkg holds:
  - default BITS, WIDTH, DEPTH constants;
  - the entry typedef {addr[BITS], data[WIDTH]};
  - the pointer-width constant $clog2(DEPTH).
- One sub-module, wb_pair_select. It is combinational and takes the two head entries plus the valid count. It produces the port-1/port-2 address, data and enable, applying the collision rule and ZERO_REG_EN.

Test Plan:
- Reset, then idle: rst_n low 2 cycles with valids high. Required: w1_en=w2_en=0, count=0, and after release in_ready=1, empty=1.
- Dual accept, dual retire: in0 (r3, 0x11111111) and in1 (r7, 0x22222222) in one cycle. Required: one cycle later wa1=3, wd1=0x11111111, wa2=7, wd2=0x22222222, both enables 1; count returns to 0.
- Collision: in0 (r5, 0xAAAA0000) and in1 (r5, 0xBBBB0000). Required: w1_en=1, wa1=5, wd1=0xBBBB0000, w2_en=0.
- Fill and backpressure:
  - Hold wb_hold=1 and push pairs until count=8. Required: in_ready=0 once count>=7, full=1 at 8, no entry lost.
  - Release wb_hold. Required: 4 cycles of dual writes in original order, across pointer wrap-around.
- Flush mid-stream: count=5 and flush=1 together with a valid pair. Required: next cycle count=0, empty=1, enables 0, and the pair is never written.
- ZERO_REG_EN:
  - Defined, push (r0, 0xDEADBEEF) with (r1, 0x1). Required: only w2_en=1 (wa2=1).
  - Undefined, same stimulus. Required: both ports are written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and entry type for the writeback commit queue.
package wb_pkg;

   localparam int WB_BITS  = 5;
   localparam int WB_WIDTH = 32;
   localparam int WB_DEPTH = 8;
   localparam int WB_PTR_W = $clog2(WB_DEPTH);

   typedef struct packed {
      logic [WB_BITS-1:0]  addr;
      logic [WB_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_pair_select.sv
// Maps the two oldest queue entries onto the register-file write ports.
// Build macro ZERO_REG_EN: entries addressed to register 0 never enable a port.
module wb_pair_select
   import wb_pkg::*;
#(
   parameter int BITS  = WB_BITS,
   parameter int WIDTH = WB_WIDTH
) (
   input  logic [BITS-1:0]  e0_addr,
   input  logic [WIDTH-1:0] e0_data,
   input  logic [BITS-1:0]  e1_addr,
   input  logic [WIDTH-1:0] e1_data,
   input  logic [1:0]       n_valid,
   output logic [BITS-1:0]  p1_addr,
   output logic [WIDTH-1:0] p1_data,
   output logic             p1_en,
   output logic [BITS-1:0]  p2_addr,
   output logic [WIDTH-1:0] p2_data,
   output logic             p2_en
);

`ifdef ZERO_REG_EN
   localparam bit ZERO_SKIP = 1'b1;
`else
   localparam bit ZERO_SKIP = 1'b0;
`endif

   logic collide;

   assign collide = (e0_addr == e1_addr);

   // port assignment with same-address merge (newer data wins on port 1)
   always_comb begin
      p1_addr = e0_addr;
      p1_data = e0_data;
      p2_addr = e1_addr;
      p2_data = e1_data;
      p1_en   = 1'b0;
      p2_en   = 1'b0;
      case (n_valid)
         2'd1: begin
            p1_en = 1'b1;
         end
         2'd2: begin
            if (collide) begin
               p1_data = e1_data;
               p1_en   = 1'b1;
            end else begin
               p1_en = 1'b1;
               p2_en = 1'b1;
            end
         end
         default: begin
            p1_en = 1'b0;
            p2_en = 1'b0;
         end
      endcase
      p1_en = p1_en && !(ZERO_SKIP && (p1_addr == BITS'(0)));
      p2_en = p2_en && !(ZERO_SKIP && (p2_addr == BITS'(0)));
   end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order writeback buffer feeding a two-write-port register file.
// Build macro ZERO_REG_EN (see wb_pair_select) suppresses writes to register 0.
module wb_commit_queue
   import wb_pkg::*;
#(
   parameter int BITS  = WB_BITS,
   parameter int WIDTH = WB_WIDTH,
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in0_valid,
   input  logic [BITS-1:0]        in0_addr,
   input  logic [WIDTH-1:0]       in0_data,
   input  logic                   in1_valid,
   input  logic [BITS-1:0]        in1_addr,
   input  logic [WIDTH-1:0]       in1_data,
   output logic                   in_ready,
   input  logic                   wb_hold,
   input  logic                   flush,
   output logic [BITS-1:0]        wa1,
   output logic [BITS-1:0]        wa2,
   output logic [WIDTH-1:0]       wd1,
   output logic [WIDTH-1:0]       wd2,
   output logic                   w1_en,
   output logic                   w2_en,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [BITS-1:0]  mem_addr_q [DEPTH];
   logic [BITS-1:0]  mem_addr_d [DEPTH];
   logic [WIDTH-1:0] mem_data_q [DEPTH];
   logic [WIDTH-1:0] mem_data_d [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d, head_p1, slot1;
   logic [CW-1:0]    count_q, count_d;
   logic             acc0, acc1;
   logic [1:0]       n_pop;

   logic [BITS-1:0]  sel_addr1, sel_addr2;
   logic [WIDTH-1:0] sel_data1, sel_data2;
   logic             sel_en1, sel_en2;

   logic [BITS-1:0]  wa1_q, wa1_d, wa2_q, wa2_d;
   logic [WIDTH-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
   logic             w1_en_q, w1_en_d, w2_en_q, w2_en_d;

   // Only registered occupancy feeds the ready decision.
   assign in_ready = (count_q <= CW'(DEPTH - 2));
   assign head_p1  = head_q + PW'(1);

   wb_pair_select #(.BITS(BITS), .WIDTH(WIDTH)) u_sel (
      .e0_addr (mem_addr_q[head_q]),
      .e0_data (mem_data_q[head_q]),
      .e1_addr (mem_addr_q[head_p1]),
      .e1_data (mem_data_q[head_p1]),
      .n_valid (n_pop),
      .p1_addr (sel_addr1),
      .p1_data (sel_data1),
      .p1_en   (sel_en1),
      .p2_addr (sel_addr2),
      .p2_data (sel_data2),
      .p2_en   (sel_en2)
   );

   // accept/pop decisions, pointer and occupancy update, output port staging
   always_comb begin
      acc0 = in0_valid && in_ready && !flush;
      acc1 = in1_valid && in_ready && !flush;
      if (flush || wb_hold || (count_q == CW'(0))) begin
         n_pop = 2'd0;
      end else if (count_q >= CW'(2)) begin
         n_pop = 2'd2;
      end else begin
         n_pop = 2'd1;
      end
      slot1 = tail_q + PW'(acc0);
      if (flush) begin
         head_d  = PW'(0);
         tail_d  = PW'(0);
         count_d = CW'(0);
      end else begin
         head_d  = head_q + PW'(n_pop);
         tail_d  = tail_q + PW'(acc0) + PW'(acc1);
         count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(n_pop);
      end
      for (int i = 0; i < DEPTH; i++) begin
         mem_addr_d[i] = (acc0 && (tail_q == PW'(i))) ? in0_addr :
                         (acc1 && (slot1 == PW'(i)))  ? in1_addr : mem_addr_q[i];
         mem_data_d[i] = (acc0 && (tail_q == PW'(i))) ? in0_data :
                         (acc1 && (slot1 == PW'(i)))  ? in1_data : mem_data_q[i];
      end
      w1_en_d = sel_en1;
      w2_en_d = sel_en2;
      wa1_d   = sel_en1 ? sel_addr1 : wa1_q;
      wd1_d   = sel_en1 ? sel_data1 : wd1_q;
      wa2_d   = sel_en2 ? sel_addr2 : wa2_q;
      wd2_d   = sel_en2 ? sel_data2 : wd2_q;
   end

   // control state and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= PW'(0);
         tail_q  <= PW'(0);
         count_q <= CW'(0);
         w1_en_q <= 1'b0;
         w2_en_q <= 1'b0;
         wa1_q   <= BITS'(0);
         wa2_q   <= BITS'(0);
         wd1_q   <= WIDTH'(0);
         wd2_q   <= WIDTH'(0);
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         w1_en_q <= w1_en_d;
         w2_en_q <= w2_en_d;
         wa1_q   <= wa1_d;
         wa2_q   <= wa2_d;
         wd1_q   <= wd1_d;
         wd2_q   <= wd2_d;
      end
   end

   // entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   assign wa1   = wa1_q;
   assign wa2   = wa2_q;
   assign wd1   = wd1_q;
   assign wd2   = wd2_q;
   assign w1_en = w1_en_q;
   assign w2_en = w2_en_q;
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == CW'(0));

endmodule
